// File: rtl/branch_predictor.sv
// ============================================================================
// Module   : branch_predictor
// Purpose  : Direct-mapped 2-bit/BTB predictor with EX training, redirect and
//            saturating performance counters.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module branch_predictor #(
    parameter int ENTRIES = 64
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [31:0] if_pc_ip,
    input  logic        if_valid_ip,
    output logic        predict_taken_op,
    output logic [31:0] predict_target_op,
    input  logic        ex_update_valid_ip,
    input  logic [31:0] ex_pc_ip,
    input  logic        ex_taken_ip,
    input  logic        ex_prediction_ip,
    input  logic [31:0] ex_target_ip,
    input  logic        hold_ip,
    output logic        redirect_valid_op,
    output logic [31:0] redirect_pc_op,
    output logic [31:0] branch_count_op,
    output logic [31:0] mispredict_count_op
);

    localparam int IDX_W = $clog2(ENTRIES);
    localparam int TAG_W = 30 - IDX_W;
    localparam logic [1:0] c_CTR_INIT  = 2'b01;
    localparam logic [1:0] c_CTR_ALLOC = 2'b10;

    logic             r_valid  [ENTRIES];
    logic [TAG_W-1:0] r_tag    [ENTRIES];
    logic [1:0]       r_ctr    [ENTRIES];
    logic [31:0]      r_target [ENTRIES];
    logic [31:0]      r_branch_count;
    logic [31:0]      r_mispredict_count;

    logic [IDX_W-1:0] w_if_idx;
    logic [TAG_W-1:0] w_if_tag;
    logic [IDX_W-1:0] w_ex_idx;
    logic [TAG_W-1:0] w_ex_tag;
    logic             w_if_hit;
    logic             w_ex_hit;
    logic             w_upd;
    logic             w_mis;
    logic             w_unused;

    assign w_if_idx = if_pc_ip[IDX_W+1:2];
    assign w_if_tag = if_pc_ip[31:IDX_W+2];
    assign w_ex_idx = ex_pc_ip[IDX_W+1:2];
    assign w_ex_tag = ex_pc_ip[31:IDX_W+2];
    assign w_unused = &{1'b0, if_pc_ip[1:0], ex_pc_ip[1:0]};

    assign w_if_hit          = if_valid_ip & r_valid[w_if_idx] & (r_tag[w_if_idx] == w_if_tag);
    assign predict_taken_op  = w_if_hit & r_ctr[w_if_idx][1];
    assign predict_target_op = predict_taken_op ? r_target[w_if_idx] : 32'd0;

    // Reset term keeps redirect quiet while the core is held in reset.
    assign w_upd = reset & ex_update_valid_ip & ~hold_ip;
    assign w_mis = w_upd & (ex_taken_ip != ex_prediction_ip);

    assign redirect_valid_op = w_mis;
    assign redirect_pc_op    = !w_mis      ? 32'd0 :
                               ex_taken_ip ? ex_target_ip : (ex_pc_ip + 32'd4);

    assign w_ex_hit = r_valid[w_ex_idx] & (r_tag[w_ex_idx] == w_ex_tag);

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < ENTRIES; i++) begin
                r_valid[i]  <= 1'b0;
                r_tag[i]    <= '0;
                r_ctr[i]    <= c_CTR_INIT;
                r_target[i] <= 32'd0;
            end
            r_branch_count     <= 32'd0;
            r_mispredict_count <= 32'd0;
        end else begin
            if (w_upd) begin
                if (w_ex_hit) begin
                    if (ex_taken_ip) begin
                        if (r_ctr[w_ex_idx] != 2'b11) begin
                            r_ctr[w_ex_idx] <= r_ctr[w_ex_idx] + 2'd1;
                        end
                        r_target[w_ex_idx] <= ex_target_ip;
                    end else if (r_ctr[w_ex_idx] != 2'b00) begin
                        r_ctr[w_ex_idx] <= r_ctr[w_ex_idx] - 2'd1;
                    end
                end else if (ex_taken_ip) begin
                    r_valid[w_ex_idx]  <= 1'b1;
                    r_tag[w_ex_idx]    <= w_ex_tag;
                    r_ctr[w_ex_idx]    <= c_CTR_ALLOC;
                    r_target[w_ex_idx] <= ex_target_ip;
                end
                if (r_branch_count != 32'hFFFF_FFFF) begin
                    r_branch_count <= r_branch_count + 32'd1;
                end
            end
            if (w_mis && (r_mispredict_count != 32'hFFFF_FFFF)) begin
                r_mispredict_count <= r_mispredict_count + 32'd1;
            end
        end
    end

    assign branch_count_op     = r_branch_count;
    assign mispredict_count_op = r_mispredict_count;

endmodule

`default_nettype wire
